prio_irq_ctrl: RTL and testbench
================================

Name: prio_irq_ctrl

Overview:
- Parametrised N-line interrupt/request controller built around a priority encoder.
- Captures requests into a pending register, with edge or level mode selectable per line. Applies a mask and presents one winning index on a registered V/Q output with an ACK claim handshake.
- Supports fixed priority (highest index wins) and round-robin mode.
- Sits between peripheral request lines and the CPU interrupt/claim logic; generalises the 16-input combinational encoder.

Parameters:
- N, 16, number of request lines; legal range 2..64, non-power-of-2 allowed.
- W, $clog2(N), index width; derived, must not be overridden.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- A  input  N  request lines; synchronous to CLK; bit i = line i.
- EDGE_SEL  input  N  per line: 1 = rising-edge capture, 0 = level.
- MASK  input  N  per line: 1 = excluded from selection; pending state still kept.
- RR_EN  input  1  0 = fixed priority, 1 = round-robin.
- ACK  input  1  claim of the presented index; meaningful only when V=1.
- V  output  1  a valid unmasked request is presented.
- Q  output  W  presented index.
- PEND  output  N  raw pending register, for status readback.

Behaviour:
- Reset (async assert, sync deassert by the integrator): V=0, Q=0, PEND=0, edge-history register=0, round-robin pointer PTR=0.
- Edge-history register: prev <= A every cycle.
- Edge line i sets:
  - PEND[i] <= 1 when A[i]=1 and prev[i]=0.
  - PEND[i] is cleared only by ACK with V=1 and Q=i.
  - Set and clear in the same cycle: set wins, so PEND[i] stays 1.
- Level line i: PEND[i] <= A[i] every cycle; ACK has no effect on it. The source must deassert.
- Candidate set C = PEND & ~MASK. On an ACK cycle the acked bit is also removed from C.
- Fixed priority: winner = highest set index in C.
- Round-robin: search upward from PTR, wrapping at N-1 to 0; the first set bit wins.
- Output register update, evaluated every cycle:
  - If V=1 and ACK=0: V and Q hold. MASK, PEND and RR_EN changes do not disturb a presented index.
  - Otherwise: V <= |C, Q <= winner, or Q <= 0 when C is empty.
- On ACK with V=1 and RR_EN=1: PTR <= (Q+1) mod N. PTR does not change in fixed mode.
- ACK while V=0 is ignored.
- Latency:
  - Edge at A[i] sampled at clock k sets PEND at edge k.
  - V/Q reflect it at edge k+1, i.e. 2 clocks from the A change.
- Back-to-back claims: the next winner is presented in the cycle after ACK, with no bubble when C remains non-empty.
- Level line still high after ACK: re-presented as early as the next cycle. This is intended; software must clear the source first.
- Mid-operation reset: all state clears immediately and asynchronously. An ACK coincident with reset is ignored.
- RR_EN toggled while V=0: applies to the next evaluation. PTR retains its value across mode switches.
- Q is never X after reset; it is 0 whenever V=0.

Decomposition:
- Package prio_pkg holds:
  - function idx_w(n), a clog2 wrapper, plus N_MAX=64.
  - enum prio_mode_e {PRIO_FIXED, PRIO_RR} for bench readability.
- Sub-module prio_enc_n: parametrised combinational encoder.
  - Inputs: vector C and start pointer.
  - Outputs: any-valid flag and index.
  - Fixed mode uses the highest-index search. RR uses rotate-by-PTR, then a lowest-index search, then un-rotate modulo N.
- Top level owns the pending, edge-history, PTR and output registers and the hold/ACK logic.

Test Plan:
- Reset with A=0 -> V=0, Q=0, PEND=0. Then pulse A[3] (edge line) for 1 cycle -> V=1, Q=3 two clocks later; stays presented after A[3] drops.
- Fixed mode, A[13] and A[5] edges in the same cycle -> Q=13. ACK -> next cycle Q=5, V=1. ACK -> V=0, PEND=0.
- RR mode, N=16, edges on lines 2, 9, 15 -> presented order 2, 9, 15 across ACKs with no bubble cycles. After the last ACK, PTR=0 and V=0.
- Mask: A[7] pending with MASK[7]=1 -> V=0 and PEND[7]=1. Clear MASK[7] -> V=1, Q=7 next cycle. Set MASK[7] while presented without ACK -> V/Q hold.
- Level line 4 held high, ACK -> re-presented Q=4. A new edge on line 4 configured as edge-mode in the same cycle as its ACK -> PEND[4] remains 1.
- N=5 (non-power-of-2), RR with PTR=4 and lines 0 and 1 pending -> wraps, Q=0. Assert RST_N=0 mid-claim -> V=0 and PEND=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared types and helpers for the priority interrupt controller.
package prio_pkg;

  localparam int unsigned N_MAX = 64;

  // Arbitration mode, mirrors the RR_EN input level.
  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  // Index width for an n-line vector; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_irq_ctrl_if.sv
// Request/claim bus between peripheral lines, CPU claim logic and the controller.
interface prio_irq_ctrl_if #(
  parameter int unsigned N = 16
);
  import prio_pkg::*;

  localparam int unsigned W = idx_w(N);

  logic [N-1:0] A;
  logic [N-1:0] EDGE_SEL;
  logic [N-1:0] MASK;
  logic         RR_EN;
  logic         ACK;
  logic         V;
  logic [W-1:0] Q;
  logic [N-1:0] PEND;

  // Requester / CPU side
  modport master (
    output A, EDGE_SEL, MASK, RR_EN, ACK,
    input  V, Q, PEND
  );

  // Controller side
  modport slave (
    input  A, EDGE_SEL, MASK, RR_EN, ACK,
    output V, Q, PEND
  );

endinterface

// File: rtl/prio_enc_n.sv
// Combinational N-input priority encoder: highest-index or round-robin from a pointer.
module prio_enc_n
  import prio_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]          i_c,
  input  logic [idx_w(N)-1:0]   i_ptr,
  input  logic                  i_rr,
  output logic                  o_any_c,
  output logic [idx_w(N)-1:0]   o_idx_c
);

  localparam int unsigned W = idx_w(N);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_rot_sel;
  logic [W-1:0] w_rr_idx;

  // Rotate candidates so rotated bit 0 is the line at the pointer
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < int'(N); j++) begin
      w_rot[j] = i_c[W'((32'(i_ptr) + 32'(j)) % N)];
    end
  end

  // Fixed priority: highest set index wins
  always_comb begin
    w_hi_idx = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (i_c[j]) w_hi_idx = W'(j);
    end
  end

  // Round-robin: lowest set position in the rotated vector
  always_comb begin
    w_rot_sel = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (w_rot[j]) w_rot_sel = W'(j);
    end
  end

  // Undo the rotation modulo N (N need not be a power of two)
  assign w_rr_idx = W'((32'(i_ptr) + 32'(w_rot_sel)) % N);

  assign o_any_c = |i_c;
  assign o_idx_c = i_rr ? w_rr_idx : w_hi_idx;

endmodule

// File: rtl/prio_irq_ctrl.sv
// N-line interrupt controller: pending capture, masking, arbitration and claim handshake.
module prio_irq_ctrl
  import prio_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  prio_irq_ctrl_if.slave  bus
);

  localparam int unsigned W = idx_w(N);

  logic [N-1:0] r_pend;
  logic [N-1:0] r_prev;
  logic         r_v;
  logic [W-1:0] r_q;
  logic [W-1:0] r_ptr;

  logic [N-1:0] w_cand;
  logic [N-1:0] w_pend_nxt;
  logic         w_ack;
  logic         w_any;
  logic [W-1:0] w_idx;
  logic         w_v_nxt;
  logic [W-1:0] w_q_nxt;
  logic [W-1:0] w_ptr_nxt;
  prio_mode_e   w_mode;

  assign w_mode = prio_mode_e'(bus.RR_EN);
  // A claim only counts while an index is actually presented
  assign w_ack  = bus.ACK & r_v;

  // Candidate set: unmasked pending lines, minus the line being claimed now
  always_comb begin
    w_cand = r_pend & ~bus.MASK;
    if (w_ack) w_cand[r_q] = 1'b0;
  end

  prio_enc_n #(
    .N (N)
  ) u_enc (
    .i_c     (w_cand),
    .i_ptr   (r_ptr),
    .i_rr    (w_mode == PRIO_RR),
    .o_any_c (w_any),
    .o_idx_c (w_idx)
  );

  // Pending next-state: edge lines set on rising edge (set beats claim), level lines follow A
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.EDGE_SEL[i]) begin
        w_pend_nxt[i] = (bus.A[i] & ~r_prev[i]) |
                        (r_pend[i] & ~(w_ack && (r_q == W'(i))));
      end else begin
        w_pend_nxt[i] = bus.A[i];
      end
    end
  end

  // Output/pointer next-state: hold a presented index until it is claimed
  always_comb begin
    w_v_nxt   = r_v;
    w_q_nxt   = r_q;
    w_ptr_nxt = r_ptr;
    if (!(r_v && !bus.ACK)) begin
      w_v_nxt = w_any;
      w_q_nxt = w_any ? w_idx : '0;
    end
    if (w_ack && (w_mode == PRIO_RR)) begin
      w_ptr_nxt = (32'(r_q) == (N - 1)) ? '0 : r_q + W'(1);
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pend <= '0;
      r_prev <= '0;
      r_v    <= 1'b0;
      r_q    <= '0;
      r_ptr  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_prev <= bus.A;
      r_v    <= w_v_nxt;
      r_q    <= w_q_nxt;
      r_ptr  <= w_ptr_nxt;
    end
  end

  assign bus.V    = r_v;
  assign bus.Q    = r_q;
  assign bus.PEND = r_pend;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Scoreboard bench for prio_irq_ctrl: a 16-line and a 5-line instance against a behavioural model.
module tb_prio_irq_ctrl;

  localparam int unsigned N0 = 16;
  localparam int unsigned N1 = 5;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;

  always #5 CLK = ~CLK;

  prio_irq_ctrl_if #(.N(N0)) bus16 ();
  prio_irq_ctrl_if #(.N(N1)) bus5 ();

  prio_irq_ctrl #(.N(N0)) dut16 (.CLK(CLK), .RST_N(RST_N), .bus(bus16));
  prio_irq_ctrl #(.N(N1)) dut5  (.CLK(CLK), .RST_N(RST_N), .bus(bus5));

  typedef struct {
    bit        v;
    int        q;
    int        ptr;
    bit [63:0] pend;
    bit [63:0] prev;
  } model_t;

  typedef struct {
    bit        v;
    int        q;
    bit [63:0] pend;
  } exp_t;

  model_t    m [2];
  bit [63:0] in_a [2];
  bit [63:0] in_es [2];
  bit [63:0] in_mk [2];
  bit        in_rr [2];
  bit        in_ack [2];
  bit [63:0] wmask [2];

  exp_t sbq0 [$];
  exp_t sbq1 [$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: one clock of the controller, written from the rules directly
  function automatic model_t step(input model_t s, input int n, input bit [63:0] a,
                                  input bit [63:0] es, input bit [63:0] mk,
                                  input bit rr, input bit ack);
    model_t    r;
    bit [63:0] c;
    bit        claim;
    int        win;
    r = s;
    claim = ack && s.v;
    c = '0;
    for (int i = 0; i < n; i++) c[i] = s.pend[i] && !mk[i] && !(claim && s.q == i);
    r.pend = '0;
    for (int i = 0; i < n; i++) begin
      if (es[i]) r.pend[i] = (a[i] && !s.prev[i]) || (s.pend[i] && !(claim && s.q == i));
      else       r.pend[i] = a[i];
    end
    if (!(s.v && !ack)) begin
      win = -1;
      if (!rr) begin
        for (int i = n - 1; i >= 0; i--) if (c[i] && win < 0) win = i;
      end else begin
        for (int k = 0; k < n; k++) if (c[(s.ptr + k) % n] && win < 0) win = (s.ptr + k) % n;
      end
      r.v = (win >= 0);
      r.q = (win >= 0) ? win : 0;
    end
    if (claim && rr) r.ptr = (s.q + 1) % n;
    r.prev = a;
    return r;
  endfunction

  // Apply current inputs to both DUTs, advance both models, queue the expected outputs
  task automatic drive_and_push();
    exp_t e;
    bus16.A = in_a[0][N0-1:0];  bus16.EDGE_SEL = in_es[0][N0-1:0];
    bus16.MASK = in_mk[0][N0-1:0];  bus16.RR_EN = in_rr[0];  bus16.ACK = in_ack[0];
    bus5.A = in_a[1][N1-1:0];   bus5.EDGE_SEL = in_es[1][N1-1:0];
    bus5.MASK = in_mk[1][N1-1:0];   bus5.RR_EN = in_rr[1];   bus5.ACK = in_ack[1];
    m[0] = step(m[0], N0, in_a[0], in_es[0], in_mk[0], in_rr[0], in_ack[0]);
    m[1] = step(m[1], N1, in_a[1], in_es[1], in_mk[1], in_rr[1], in_ack[1]);
    e.v = m[0].v; e.q = m[0].q; e.pend = m[0].pend; sbq0.push_back(e);
    e.v = m[1].v; e.q = m[1].q; e.pend = m[1].pend; sbq1.push_back(e);
  endtask

  task automatic cyc(input int d, input bit [63:0] a, input bit [63:0] mk,
                     input bit rr, input bit ack);
    @(negedge CLK);
    in_ack[0] = 1'b0;
    in_ack[1] = 1'b0;
    in_a[d]   = a & wmask[d];
    in_mk[d]  = mk & wmask[d];
    in_rr[d]  = rr;
    in_ack[d] = ack;
    drive_and_push();
  endtask

  // Direct look at one DUT right after the next clock edge
  task automatic peek(input int d, input bit v, input int q, input bit [63:0] pend);
    @(posedge CLK);
    #2;
    if (d == 0) begin
      chk("peek16.V", 64'(bus16.V), 64'(v));
      chk("peek16.Q", 64'(bus16.Q), 64'(q));
      chk("peek16.PEND", 64'(bus16.PEND), pend);
    end else begin
      chk("peek5.V", 64'(bus5.V), 64'(v));
      chk("peek5.Q", 64'(bus5.Q), 64'(q));
      chk("peek5.PEND", 64'(bus5.PEND), pend);
    end
  endtask

  // Asynchronous reset; outputs must clear before any clock edge
  task automatic do_reset(input bit ack_during);
    RST_N = 1'b0;
    bus16.ACK = ack_during;
    bus5.ACK  = ack_during;
    #1;
    chk("rst16.V", 64'(bus16.V), 64'd0);
    chk("rst16.Q", 64'(bus16.Q), 64'd0);
    chk("rst16.PEND", 64'(bus16.PEND), 64'd0);
    chk("rst5.V", 64'(bus5.V), 64'd0);
    chk("rst5.Q", 64'(bus5.Q), 64'd0);
    chk("rst5.PEND", 64'(bus5.PEND), 64'd0);
    sbq0.delete();
    sbq1.delete();
    for (int d = 0; d < 2; d++) begin
      m[d] = '{v: 1'b0, q: 0, ptr: 0, pend: 64'd0, prev: 64'd0};
      in_a[d] = '0;
      in_mk[d] = '0;
      in_ack[d] = 1'b0;
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    drive_and_push();
  endtask

  // Monitor: compare every presented output against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sbq0.size() > 0) begin
        e = sbq0.pop_front();
        chk("sb16.V", 64'(bus16.V), 64'(e.v));
        chk("sb16.Q", 64'(bus16.Q), 64'(e.q));
        chk("sb16.PEND", 64'(bus16.PEND), e.pend);
      end
      if (sbq1.size() > 0) begin
        e = sbq1.pop_front();
        chk("sb5.V", 64'(bus5.V), 64'(e.v));
        chk("sb5.Q", 64'(bus5.Q), 64'(e.q));
        chk("sb5.PEND", 64'(bus5.PEND), e.pend);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wmask[0] = 64'hFFFF;
    wmask[1] = 64'h1F;
    in_es[0] = 64'hFFFF;
    in_es[1] = 64'h1F;
    in_rr[0] = 1'b0;
    in_rr[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_a[d] = '0; in_mk[d] = '0; in_ack[d] = 1'b0;
    end
    bus16.A = '0; bus16.EDGE_SEL = '1; bus16.MASK = '0; bus16.RR_EN = 1'b0; bus16.ACK = 1'b0;
    bus5.A = '0;  bus5.EDGE_SEL = '1;  bus5.MASK = '0;  bus5.RR_EN = 1'b0;  bus5.ACK = 1'b0;
    #2;
    do_reset(1'b0);

    // Single edge pulse on line 3: presented two clocks later and held
    cyc(0, 64'h0008, 0, 0, 0);
    cyc(0, 64'h0000, 0, 0, 0);  peek(0, 1, 3, 64'h0008);
    cyc(0, 64'h0000, 0, 0, 0);  peek(0, 1, 3, 64'h0008);
    cyc(0, 64'h0000, 0, 0, 1);  peek(0, 0, 0, 64'h0000);

    // Fixed priority: 13 before 5, back-to-back claims
    cyc(0, 64'h2020, 0, 0, 0);
    cyc(0, 64'h0000, 0, 0, 0);  peek(0, 1, 13, 64'h2020);
    cyc(0, 64'h0000, 0, 0, 1);  peek(0, 1, 5, 64'h0020);
    cyc(0, 64'h0000, 0, 0, 1);  peek(0, 0, 0, 64'h0000);

    // Round-robin order 2, 9, 15 then pointer back at 0
    cyc(0, 64'h8204, 0, 1, 0);
    cyc(0, 64'h0000, 0, 1, 0);  peek(0, 1, 2, 64'h8204);
    cyc(0, 64'h0000, 0, 1, 1);  peek(0, 1, 9, 64'h8200);
    cyc(0, 64'h0000, 0, 1, 1);  peek(0, 1, 15, 64'h8000);
    cyc(0, 64'h0000, 0, 1, 1);  peek(0, 0, 0, 64'h0000);
    cyc(0, 64'h8002, 0, 1, 0);
    cyc(0, 64'h0000, 0, 1, 0);  peek(0, 1, 1, 64'h8002);
    cyc(0, 64'h0000, 0, 1, 1);
    cyc(0, 64'h0000, 0, 1, 1);

    // Masking keeps pending, hides line 7, and never disturbs a presented index
    cyc(0, 64'h0080, 64'h80, 0, 0);
    cyc(0, 64'h0000, 64'h80, 0, 0);  peek(0, 0, 0, 64'h0080);
    cyc(0, 64'h0000, 64'h00, 0, 0);  peek(0, 1, 7, 64'h0080);
    cyc(0, 64'h0000, 64'h80, 0, 0);  peek(0, 1, 7, 64'h0080);
    cyc(0, 64'h0000, 64'h00, 0, 1);  peek(0, 0, 0, 64'h0000);

    // Level line 4 is re-presented after its claim while still high
    in_es[0] = 64'hFFEF;
    cyc(0, 64'h0010, 0, 0, 0);  peek(0, 0, 0, 64'h0010);
    cyc(0, 64'h0010, 0, 0, 0);  peek(0, 1, 4, 64'h0010);
    cyc(0, 64'h0010, 0, 0, 1);  peek(0, 0, 0, 64'h0010);
    cyc(0, 64'h0010, 0, 0, 0);  peek(0, 1, 4, 64'h0010);
    cyc(0, 64'h0000, 0, 0, 1);  peek(0, 0, 0, 64'h0000);

    // Edge line 4: new edge in the claim cycle keeps it pending
    in_es[0] = 64'hFFFF;
    cyc(0, 64'h0010, 0, 0, 0);
    cyc(0, 64'h0000, 0, 0, 0);  peek(0, 1, 4, 64'h0010);
    cyc(0, 64'h0010, 0, 0, 1);  peek(0, 0, 0, 64'h0010);
    cyc(0, 64'h0000, 0, 0, 0);  peek(0, 1, 4, 64'h0010);
    cyc(0, 64'h0000, 0, 0, 1);  peek(0, 0, 0, 64'h0000);

    // Five lines, round-robin pointer at 4 wraps to line 0
    cyc(1, 64'h08, 0, 1, 0);
    cyc(1, 64'h00, 0, 1, 0);  peek(1, 1, 3, 64'h08);
    cyc(1, 64'h00, 0, 1, 1);  peek(1, 0, 0, 64'h00);
    cyc(1, 64'h03, 0, 1, 0);
    cyc(1, 64'h00, 0, 1, 0);  peek(1, 1, 0, 64'h03);
    cyc(1, 64'h00, 0, 1, 1);  peek(1, 1, 1, 64'h02);

    // Reset in the middle of a claim, with ACK asserted
    @(negedge CLK);
    do_reset(1'b1);

    // Randomised traffic on both instances
    for (int c = 0; c < 2000; c++) begin
      for (int d = 0; d < 2; d++) begin
        in_a[d] = ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) & wmask[d];
        if (c % 97 == 0) begin
          in_es[d] = {$urandom, $urandom} & wmask[d];
          in_rr[d] = 1'($urandom_range(0, 1));
        end
        if (c % 13 == 0) in_mk[d] = ({$urandom, $urandom} & {$urandom, $urandom}) & wmask[d];
        in_ack[d] = m[d].v ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      end
      @(negedge CLK);
      drive_and_push();
      if (c == 1100) begin
        @(negedge CLK);
        do_reset(1'($urandom_range(0, 1)));
      end
    end

    @(posedge CLK);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
